// File: rtl/cmp_share_arbiter_if.sv
// Bundle of requester, comparator and result-channel signals around the
// shared comparator arbiter. The arbiter uses the slave view; the
// requesters, comparator and result consumer together form the master view.
interface cmp_share_arbiter_if #(
   parameter int W     = 6,
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
);
   // requester side
   logic [N_REQ-1:0]   req;
   logic [N_REQ*W-1:0] a_flat;
   logic [N_REQ*W-1:0] b_flat;
   logic [N_REQ-1:0]   ack;
   // shared comparator side
   logic [W-1:0]       cmp_a;
   logic [W-1:0]       cmp_b;
   logic               cmp_gte;
   // result channel
   logic               res_valid;
   logic               res_ready;
   logic               res_gte;
   logic [ID_W-1:0]    res_id;
   // status
   logic               busy;

   modport slave (
      input  req, a_flat, b_flat, cmp_gte, res_ready,
      output ack, cmp_a, cmp_b, res_valid, res_gte, res_id, busy
   );

   modport master (
      output req, a_flat, b_flat, cmp_gte, res_ready,
      input  ack, cmp_a, cmp_b, res_valid, res_gte, res_id, busy
   );
endinterface

// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter that time-shares one external W-bit >= comparator
// among N_REQ requesters. A grant captures the winner's operand pair onto
// cmp_a/cmp_b, the comparator output is registered one cycle later, and the
// result is returned with the requester index over a valid/ready channel.
module cmp_share_arbiter #(
   parameter int W     = 6,
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input logic               clk,
   input logic               reset,
   cmp_share_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_reg;
   logic [ID_W-1:0]   last_reg;
   logic [N_REQ-1:0]  ack_reg;
   logic [W-1:0]      cmp_a_reg;
   logic [W-1:0]      cmp_b_reg;
   logic              res_valid_reg;
   logic              res_gte_reg;
   logic [ID_W-1:0]   res_id_reg;
   logic              busy_reg;

   // Unpacked operand views and the "above the pointer" request mask
   logic [W-1:0]      a_arr [N_REQ];
   logic [W-1:0]      b_arr [N_REQ];
   logic [N_REQ-1:0]  req_hi;

   logic [ID_W-1:0]   grant_lo_next;
   logic [ID_W-1:0]   grant_hi_next;
   logic              hi_found_next;
   logic [ID_W-1:0]   grant_id_next;
   logic [N_REQ-1:0]  grant_onehot_next;

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
         assign a_arr[gi]  = bus.a_flat[gi*W +: W];
         assign b_arr[gi]  = bus.b_flat[gi*W +: W];
         // Requesters strictly after the last winner get first look.
         assign req_hi[gi] = bus.req[gi] && (ID_W'(gi) > last_reg);
      end
   endgenerate

   // Round-robin winner: lowest index above the pointer, else lowest overall.
   // This is the same as scanning last+1, last+2, ... modulo N_REQ.
   always_comb begin
      grant_lo_next = '0;
      grant_hi_next = '0;
      hi_found_next = 1'b0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (bus.req[i]) begin
            grant_lo_next = ID_W'(i);
         end
         if (req_hi[i]) begin
            grant_hi_next = ID_W'(i);
            hi_found_next = 1'b1;
         end
      end
      grant_id_next     = hi_found_next ? grant_hi_next : grant_lo_next;
      grant_onehot_next = {{(N_REQ-1){1'b0}}, 1'b1} << grant_id_next;
   end

   // Sequencer: grant/capture in IDLE, sample comparator in EVAL, hold result in DONE.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         last_reg      <= ID_W'(N_REQ - 1);
         ack_reg       <= '0;
         cmp_a_reg     <= '0;
         cmp_b_reg     <= '0;
         res_valid_reg <= 1'b0;
         res_gte_reg   <= 1'b0;
         res_id_reg    <= '0;
         busy_reg      <= 1'b0;
      end else begin
         // ack is a single-cycle pulse; only the grant edge raises it.
         ack_reg <= '0;
         case (state_reg)
            IDLE: begin
               if (|bus.req) begin
                  cmp_a_reg  <= a_arr[grant_id_next];
                  cmp_b_reg  <= b_arr[grant_id_next];
                  res_id_reg <= grant_id_next;
                  last_reg   <= grant_id_next;
                  ack_reg    <= grant_onehot_next;
                  busy_reg   <= 1'b1;
                  state_reg  <= EVAL;
               end
            end
            EVAL: begin
               // cmp_a/cmp_b have been stable for a full cycle here.
               res_gte_reg   <= bus.cmp_gte;
               res_valid_reg <= 1'b1;
               state_reg     <= DONE;
            end
            DONE: begin
               // Requests are ignored until the result is consumed.
               if (res_valid_reg && bus.res_ready) begin
                  res_valid_reg <= 1'b0;
                  busy_reg      <= 1'b0;
                  state_reg     <= IDLE;
               end
            end
            default: begin
               res_valid_reg <= 1'b0;
               busy_reg      <= 1'b0;
               state_reg     <= IDLE;
            end
         endcase
      end
   end

   assign bus.ack       = ack_reg;
   assign bus.cmp_a     = cmp_a_reg;
   assign bus.cmp_b     = cmp_b_reg;
   assign bus.res_valid = res_valid_reg;
   assign bus.res_gte   = res_gte_reg;
   assign bus.res_id    = res_id_reg;
   assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Directed bench for cmp_share_arbiter. Models the external comparator,
// walks through grant/result sequences and checks each point against
// hand-computed values.
module tb_cmp_share_arbiter;

   localparam int W     = 6;
   localparam int N_REQ = 4;
   localparam int ID_W  = 2;

   logic clk;
   logic reset;
   int   tests_run;
   int   failed;

   cmp_share_arbiter_if #(.W(W), .N_REQ(N_REQ), .ID_W(ID_W)) bus ();

   cmp_share_arbiter #(.W(W), .N_REQ(N_REQ), .ID_W(ID_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // The shared comparator itself lives outside the arbiter.
   assign bus.cmp_gte = (bus.cmp_a >= bus.cmp_b);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      bus.a_flat[i*W +: W] = a;
      bus.b_flat[i*W +: W] = b;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.req = '0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // One full transaction with res_ready high: grant, result, return to IDLE.
   task automatic do_txn(input string tag, input logic [N_REQ-1:0] mask,
                         input int exp_id, input logic exp_gte);
      bus.req = mask;
      tick();
      check({tag, "_ack"}, 32'(bus.ack), 32'(1 << exp_id));
      bus.req = '0;
      tick();
      check({tag, "_valid"}, 32'(bus.res_valid), 32'd1);
      check({tag, "_id"}, 32'(bus.res_id), 32'(exp_id));
      check({tag, "_gte"}, 32'(bus.res_gte), 32'(exp_gte));
      $display("[TB] txn %s id=%0d gte=%0d", tag, bus.res_id, bus.res_gte);
      tick();
      check({tag, "_release"}, 32'(bus.res_valid), 32'd0);
   endtask

   int          exp_ids [5] = '{0, 1, 2, 3, 0};
   logic        exp_gtes[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
   int          alt_ids [4] = '{0, 2, 0, 2};

   initial begin
      tests_run     = 0;
      failed        = 0;
      reset         = 1'b1;
      bus.req       = '0;
      bus.a_flat    = '0;
      bus.b_flat    = '0;
      bus.res_ready = 1'b1;

      // Reset state
      do_reset();
      check("rst_ack", 32'(bus.ack), 32'd0);
      check("rst_cmp_a", 32'(bus.cmp_a), 32'd0);
      check("rst_cmp_b", 32'(bus.cmp_b), 32'd0);
      check("rst_valid", 32'(bus.res_valid), 32'd0);
      check("rst_gte", 32'(bus.res_gte), 32'd0);
      check("rst_id", 32'(bus.res_id), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);

      // Single request from requester 0
      set_ops(0, 6'b111111, 6'b100000);
      bus.req = 4'b0001;
      tick();
      check("t1_ack", 32'(bus.ack), 32'b0001);
      check("t1_busy", 32'(bus.busy), 32'd1);
      check("t1_cmp_a", 32'(bus.cmp_a), 32'd63);
      check("t1_cmp_b", 32'(bus.cmp_b), 32'd32);
      check("t1_valid_early", 32'(bus.res_valid), 32'd0);
      bus.req = '0;
      tick();
      check("t1_ack_off", 32'(bus.ack), 32'd0);
      check("t1_valid", 32'(bus.res_valid), 32'd1);
      check("t1_gte", 32'(bus.res_gte), 32'd1);
      check("t1_id", 32'(bus.res_id), 32'd0);
      $display("[TB] txn t1 id=%0d gte=%0d", bus.res_id, bus.res_gte);
      tick();
      check("t1_release", 32'(bus.res_valid), 32'd0);
      check("t1_idle", 32'(bus.busy), 32'd0);

      // All requesters held high: round-robin order, one result every 3 cycles
      do_reset();
      set_ops(0, 6'b101010, 6'b010101);
      set_ops(1, 6'b000111, 6'b111000);
      set_ops(2, 6'b111110, 6'b011110);
      set_ops(3, 6'b100001, 6'b001000);
      bus.req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("t2_ack", 32'(bus.ack), 32'(1 << exp_ids[k]));
         tick();
         check("t2_valid", 32'(bus.res_valid), 32'd1);
         check("t2_id", 32'(bus.res_id), 32'(exp_ids[k]));
         check("t2_gte", 32'(bus.res_gte), 32'(exp_gtes[k]));
         $display("[TB] txn t2 id=%0d gte=%0d", bus.res_id, bus.res_gte);
         tick();
         check("t2_release", 32'(bus.res_valid), 32'd0);
      end
      bus.req = '0;
      tick();

      // Back-pressure: result held while res_ready is low, no grants meanwhile
      do_reset();
      bus.req = 4'b0001;
      tick();
      check("t3_ack0", 32'(bus.ack), 32'b0001);
      bus.req = 4'b0110;
      bus.res_ready = 1'b0;
      tick();
      check("t3_valid", 32'(bus.res_valid), 32'd1);
      for (int k = 0; k < 5; k++) begin
         tick();
         check("t3_hold_valid", 32'(bus.res_valid), 32'd1);
         check("t3_hold_id", 32'(bus.res_id), 32'd0);
         check("t3_hold_gte", 32'(bus.res_gte), 32'd1);
         check("t3_hold_ack", 32'(bus.ack), 32'd0);
      end
      $display("[TB] txn t3 id=%0d gte=%0d", bus.res_id, bus.res_gte);
      bus.res_ready = 1'b1;
      tick();
      check("t3_release", 32'(bus.res_valid), 32'd0);
      check("t3_release_ack", 32'(bus.ack), 32'd0);
      tick();
      check("t3_ack1", 32'(bus.ack), 32'b0010);
      tick();
      check("t3_id1", 32'(bus.res_id), 32'd1);
      check("t3_gte1", 32'(bus.res_gte), 32'd0);
      $display("[TB] txn t3 id=%0d gte=%0d", bus.res_id, bus.res_gte);
      tick();
      tick();
      check("t3_ack2", 32'(bus.ack), 32'b0100);
      bus.req = '0;
      tick();
      check("t3_id2", 32'(bus.res_id), 32'd2);
      check("t3_gte2", 32'(bus.res_gte), 32'd1);
      $display("[TB] txn t3 id=%0d gte=%0d", bus.res_id, bus.res_gte);
      tick();
      check("t3_end", 32'(bus.res_valid), 32'd0);

      // Equal operands at both extremes
      do_reset();
      set_ops(0, 6'b000000, 6'b000000);
      set_ops(1, 6'b111111, 6'b111111);
      do_txn("t4_zero", 4'b0001, 0, 1'b1);
      do_txn("t4_ones", 4'b0010, 1, 1'b1);

      // Reset during EVAL aborts the transaction
      set_ops(0, 6'b000001, 6'b000010);
      set_ops(3, 6'b110000, 6'b000011);
      bus.req = 4'b0001;
      tick();
      check("t5_eval_ack", 32'(bus.ack), 32'b0001);
      bus.req = '0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t5_eval_ack_off", 32'(bus.ack), 32'd0);
      check("t5_eval_valid", 32'(bus.res_valid), 32'd0);
      check("t5_eval_busy", 32'(bus.busy), 32'd0);
      tick();
      check("t5_eval_no_result", 32'(bus.res_valid), 32'd0);

      // Reset during DONE discards the pending result
      bus.req = 4'b0001;
      tick();
      bus.req = '0;
      tick();
      check("t5_done_valid", 32'(bus.res_valid), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t5_done_ack", 32'(bus.ack), 32'd0);
      check("t5_done_valid_off", 32'(bus.res_valid), 32'd0);
      check("t5_done_busy", 32'(bus.busy), 32'd0);

      // Pointer back at N_REQ-1: requester 0 beats 3, then 3 alone
      do_txn("t5_ptr", 4'b1001, 0, 1'b0);
      do_txn("t5_req3", 4'b1000, 3, 1'b1);

      // req[0] re-asserted after each ack while req[2] stays high
      do_reset();
      set_ops(0, 6'b000100, 6'b000101);
      set_ops(2, 6'b010000, 6'b001111);
      bus.req = 4'b0101;
      for (int k = 0; k < 4; k++) begin
         bus.req = 4'b0101;
         tick();
         check("t6_ack", 32'(bus.ack), 32'(1 << alt_ids[k]));
         bus.req = 4'b0100;
         tick();
         check("t6_id", 32'(bus.res_id), 32'(alt_ids[k]));
         check("t6_gte", 32'(bus.res_gte), 32'(alt_ids[k] == 2 ? 1 : 0));
         $display("[TB] txn t6 id=%0d gte=%0d", bus.res_id, bus.res_gte);
         bus.req = 4'b0101;
         tick();
         check("t6_release", 32'(bus.res_valid), 32'd0);
      end
      bus.req = '0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

   // Hard stop so the run always ends even if the sequence stalls.
   initial begin
      #200000;
      $display("[TB] FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
